id_ex_decode: RTL and testbench

Instruction decoder and ID/EX pipeline register for the 5-stage MIPS core. It is the issuing end of the ALU control interface. Each cycle it accepts the ID-stage instruction and produces the registered EX-stage control bundle: ALU operation code, operand select, shift amount, and memory/writeback controls. It also detects load-use hazards, holds the front end on a hazard, and inserts bubbles. It handles stall and flush requests from the hazard/branch logic.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/ctrl_decode.sv | 119 +++++++++++
 rtl/id_ex_decode.sv | 89 ++++++++
 tb/tb_id_ex_decode.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode path: ALU operation codes,
// opcode/funct constants and the EX-stage control bundle.
package mips_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_SLT     = 4'b0010;
  localparam logic [3:0] ALU_SRL     = 4'b0011;
  localparam logic [3:0] ALU_SRLV    = 4'b0100;
  localparam logic [3:0] ALU_SLL     = 4'b0101;
  localparam logic [3:0] ALU_SLLV    = 4'b0110;
  localparam logic [3:0] ALU_SRA     = 4'b0111;
  localparam logic [3:0] ALU_SRAV    = 4'b1000;
  localparam logic [3:0] ALU_AND     = 4'b1001;
  localparam logic [3:0] ALU_NOR     = 4'b1010;
  localparam logic [3:0] ALU_OR      = 4'b1011;
  localparam logic [3:0] ALU_XOR     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       zero_ext;
    logic [4:0] shamt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       beq;
    logic       bne;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: instruction word to EX control bundle,
// plus which register fields are genuinely read (for hazard detection).
module ctrl_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        rs_used,
  output logic        rt_used
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       legal;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Decode opcode/funct; unsupported encodings collapse to the illegal bundle.
  always_comb begin
    ctrl       = CTRL_BUBBLE;
    rs_used    = 1'b0;
    rt_used    = 1'b0;
    legal      = 1'b1;
    ctrl.shamt = instr[10:6];
    ctrl.rs    = instr[25:21];
    ctrl.rt    = instr[20:16];

    case (opcode)
      OP_RTYPE: begin
        ctrl.dest      = instr[15:11];
        ctrl.reg_write = 1'b1;
        rs_used        = 1'b1;
        rt_used        = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_ctrl = ALU_SUB;
          FN_AND:          ctrl.alu_ctrl = ALU_AND;
          FN_OR:           ctrl.alu_ctrl = ALU_OR;
          FN_XOR:          ctrl.alu_ctrl = ALU_XOR;
          FN_NOR:          ctrl.alu_ctrl = ALU_NOR;
          FN_SLT:          ctrl.alu_ctrl = ALU_SLT;
          FN_SLLV:         ctrl.alu_ctrl = ALU_SLLV;
          FN_SRLV:         ctrl.alu_ctrl = ALU_SRLV;
          FN_SRAV:         ctrl.alu_ctrl = ALU_SRAV;
          // Constant shifts take the amount from shamt, so rs is not read.
          FN_SLL: begin
            ctrl.alu_ctrl = ALU_SLL;
            rs_used       = 1'b0;
          end
          FN_SRL: begin
            ctrl.alu_ctrl = ALU_SRL;
            rs_used       = 1'b0;
          end
          FN_SRA: begin
            ctrl.alu_ctrl = ALU_SRA;
            rs_used       = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.dest      = instr[20:16];
        ctrl.reg_write = 1'b1;
        rs_used        = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_ctrl  = (opcode == OP_ANDI) ? ALU_AND :
                         (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.dest      = instr[20:16];
        ctrl.reg_write = 1'b1;
        rs_used        = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.dest       = instr[20:16];
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        rs_used         = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.dest      = instr[20:16];
        ctrl.mem_write = 1'b1;
        rs_used        = 1'b1;
        rt_used        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.dest     = instr[20:16];
        ctrl.beq      = (opcode == OP_BEQ);
        ctrl.bne      = (opcode == OP_BNE);
        rs_used       = 1'b1;
        rt_used       = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Illegal: keep only the raw register/shamt fields, no side effects.
    if (!legal) begin
      ctrl          = CTRL_BUBBLE;
      ctrl.shamt    = instr[10:6];
      ctrl.rs       = instr[25:21];
      ctrl.rt       = instr[20:16];
      ctrl.alu_ctrl = ALU_ILLEGAL;
      ctrl.illegal  = 1'b1;
      rs_used       = 1'b0;
      rt_used       = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_decode.sv
// ID-stage decode plus ID/EX pipeline register with load-use hazard
// detection, bubble insertion, external stall and flush.
module id_ex_decode
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        stall,
  input  logic        flush,
  output logic        hazard_stall,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_ctrl,
  output logic        ex_alu_src,
  output logic        ex_zero_ext,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_beq,
  output logic        ex_bne,
  output logic        ex_illegal
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  rs_used;
  logic  rt_used;
  logic  ex_valid_q;
  logic  load_use;

  ctrl_decode u_ctrl_decode (
    .instr   (id_instr),
    .ctrl    (id_ctrl),
    .rs_used (rs_used),
    .rt_used (rt_used)
  );

  // Load-use compare against the current EX contents only; a flush kills
  // the ID instruction so there is nothing to hold the front end for.
  always_comb begin
    load_use = id_valid && ex_valid_q && ex_ctrl.mem_read && (ex_ctrl.dest != 5'd0) &&
               ((rs_used && (id_ctrl.rs == ex_ctrl.dest)) ||
                (rt_used && (id_ctrl.rt == ex_ctrl.dest)));
    hazard_stall = load_use && !flush;
  end

  // EX register: flush > stall > hazard bubble > issue (invalid ID issues a bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl    <= CTRL_BUBBLE;
      ex_valid_q <= 1'b0;
    end else if (flush) begin
      ex_ctrl    <= CTRL_BUBBLE;
      ex_valid_q <= 1'b0;
    end else if (stall) begin
      ex_ctrl    <= ex_ctrl;
      ex_valid_q <= ex_valid_q;
    end else if (load_use || !id_valid) begin
      ex_ctrl    <= CTRL_BUBBLE;
      ex_valid_q <= 1'b0;
    end else begin
      ex_ctrl    <= id_ctrl;
      ex_valid_q <= 1'b1;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alu_ctrl   = ex_ctrl.alu_ctrl;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_zero_ext   = ex_ctrl.zero_ext;
  assign ex_shamt      = ex_ctrl.shamt;
  assign ex_rs         = ex_ctrl.rs;
  assign ex_rt         = ex_ctrl.rt;
  assign ex_dest       = ex_ctrl.dest;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_beq        = ex_ctrl.beq;
  assign ex_bne        = ex_ctrl.bne;
  assign ex_illegal    = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_decode.sv
// Directed bench for id_ex_decode: decode table plus hazard/stall/flush/reset sequences.
module tb_id_ex_decode;

  logic        clk;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        stall;
  logic        flush;
  logic        hazard_stall;
  logic        ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_alu_src;
  logic        ex_zero_ext;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_beq;
  logic        ex_bne;
  logic        ex_illegal;

  id_ex_decode dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .stall        (stall),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .ex_valid     (ex_valid),
    .ex_alu_ctrl  (ex_alu_ctrl),
    .ex_alu_src   (ex_alu_src),
    .ex_zero_ext  (ex_zero_ext),
    .ex_shamt     (ex_shamt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_dest      (ex_dest),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_beq       (ex_beq),
    .ex_bne       (ex_bne),
    .ex_illegal   (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        src;
    logic        zext;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        beq;
    logic        bne;
    logic        ill;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [32:0] dut_pack();
    return {ex_valid, ex_alu_ctrl, ex_alu_src, ex_zero_ext, ex_shamt, ex_rs, ex_rt,
            ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
            ex_beq, ex_bne, ex_illegal};
  endfunction

  function automatic logic [32:0] exp_pack(vec_t v);
    return {1'b1, v.alu, v.src, v.zext, v.instr[10:6], v.instr[25:21], v.instr[20:16],
            v.dest, v.rw, v.mr, v.mw, v.m2r, v.beq, v.bne, v.ill};
  endfunction

  function automatic vec_t find(logic [31:0] instr);
    vec_t r;
    r = vq[0];
    foreach (vq[i]) if (vq[i].instr == instr) r = vq[i];
    return r;
  endfunction

  task automatic check(string name, logic [32:0] act, logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [31:0] instr);
    id_instr = instr;
    id_valid = 1'b1;
    step();
  endtask

  initial begin
    // instr, alu, src, zext, dest, rw, mr, mw, m2r, beq, bne, ill
    vq.push_back('{32'h00221820, 4'h0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0}); // add $3,$1,$2
    vq.push_back('{32'h00221821, 4'h0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0}); // addu
    vq.push_back('{32'h00C72822, 4'h1, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 0}); // sub $5,$6,$7
    vq.push_back('{32'h00C72823, 4'h1, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 0}); // subu
    vq.push_back('{32'h00224024, 4'h9, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0}); // and
    vq.push_back('{32'h00224025, 4'hB, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0}); // or
    vq.push_back('{32'h00224026, 4'hC, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0}); // xor
    vq.push_back('{32'h00224027, 4'hA, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0}); // nor
    vq.push_back('{32'h0022402A, 4'h2, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0}); // slt
    vq.push_back('{32'h000220C0, 4'h5, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 0}); // sll $4,$2,3
    vq.push_back('{32'h000220C2, 4'h3, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 0}); // srl
    vq.push_back('{32'h000220C3, 4'h7, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 0}); // sra $4,$2,3
    vq.push_back('{32'h00222004, 4'h6, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 0}); // sllv
    vq.push_back('{32'h00222006, 4'h4, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 0}); // srlv
    vq.push_back('{32'h00222007, 4'h8, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 0}); // srav
    vq.push_back('{32'h20220005, 4'h0, 1, 0, 5'd2, 1, 0, 0, 0, 0, 0, 0}); // addi $2,$1,5
    vq.push_back('{32'h24220005, 4'h0, 1, 0, 5'd2, 1, 0, 0, 0, 0, 0, 0}); // addiu
    vq.push_back('{32'h30220005, 4'h9, 1, 1, 5'd2, 1, 0, 0, 0, 0, 0, 0}); // andi
    vq.push_back('{32'h34220005, 4'hB, 1, 1, 5'd2, 1, 0, 0, 0, 0, 0, 0}); // ori
    vq.push_back('{32'h38220005, 4'hC, 1, 1, 5'd2, 1, 0, 0, 0, 0, 0, 0}); // xori
    vq.push_back('{32'h8C220004, 4'h0, 1, 0, 5'd2, 1, 1, 0, 1, 0, 0, 0}); // lw $2,4($1)
    vq.push_back('{32'hAC220004, 4'h0, 1, 0, 5'd2, 0, 0, 1, 0, 0, 0, 0}); // sw $2,4($1)
    vq.push_back('{32'h10220004, 4'h1, 0, 0, 5'd2, 0, 0, 0, 0, 1, 0, 0}); // beq
    vq.push_back('{32'h14220004, 4'h1, 0, 0, 5'd2, 0, 0, 0, 0, 0, 1, 0}); // bne
    vq.push_back('{32'hFC000000, 4'hF, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1}); // bad opcode
    vq.push_back('{32'h00224001, 4'hF, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1}); // bad funct
    vq.push_back('{32'h8C200004, 4'h0, 1, 0, 5'd0, 1, 1, 0, 1, 0, 0, 0}); // lw $0,4($1)
    vq.push_back('{32'h8C210004, 4'h0, 1, 0, 5'd1, 1, 1, 0, 1, 0, 0, 0}); // lw $1,4($1)
    vq.push_back('{32'h00411820, 4'h0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0}); // add $3,$2,$1
    vq.push_back('{32'h002220C0, 4'h5, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 0}); // sll, rs field=1
    vq.push_back('{32'h20220001, 4'h0, 1, 0, 5'd2, 1, 0, 0, 0, 0, 0, 0}); // addi $2,$1,1

    rst_n = 1'b0; id_instr = 32'h00221820; id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    @(posedge clk); #2;
    check("reset_outputs", dut_pack(), 33'd0);
    check("reset_hazard", {32'd0, hazard_stall}, 33'd0);
    rst_n = 1'b1;

    // Decode table, each followed by an invalid slot that must bubble.
    foreach (vq[i]) begin
      issue(vq[i].instr);
      check($sformatf("decode_%08h", vq[i].instr), dut_pack(), exp_pack(vq[i]));
      id_valid = 1'b0;
      step();
      check("invalid_bubble", dut_pack(), 33'd0);
    end

    // lw $2 then dependent add: one hazard cycle, bubble, then add issues.
    issue(32'h8C220004);
    id_instr = 32'h00411820;
    #1;
    check("lw_add_hazard", {32'd0, hazard_stall}, 33'd1);
    step();
    check("lw_add_bubble", dut_pack(), 33'd0);
    check("lw_add_hazard_clear", {32'd0, hazard_stall}, 33'd0);
    step();
    check("lw_add_issue", dut_pack(), exp_pack(find(32'h00411820)));
    check("lw_add_rs", {28'd0, ex_rs}, 33'd2);

    // sra after lw $2: rt dependency.
    issue(32'h8C220004);
    id_instr = 32'h000220C3;
    #1;
    check("lw_sra_hazard", {32'd0, hazard_stall}, 33'd1);
    step();
    step();
    check("sra_issue", dut_pack(), exp_pack(find(32'h000220C3)));

    // sra after lw $0: never a hazard.
    issue(32'h8C200004);
    id_instr = 32'h000220C3;
    #1;
    check("lw0_sra_nohazard", {32'd0, hazard_stall}, 33'd0);
    step();
    check("lw0_sra_issue", dut_pack(), exp_pack(find(32'h000220C3)));

    // sll does not read rs even when the field matches the load target.
    issue(32'h8C210004);
    id_instr = 32'h002220C0;
    #1;
    check("sll_rs_unused", {32'd0, hazard_stall}, 33'd0);
    step();

    // addi reads rt only as a destination.
    issue(32'h8C220004);
    id_instr = 32'h20220001;
    #1;
    check("addi_rt_unused", {32'd0, hazard_stall}, 33'd0);
    step();

    // Stall with hazard pending: reported, EX holds the load.
    issue(32'h8C220004);
    id_instr = 32'h00411820;
    stall = 1'b1;
    #1;
    check("stall_hazard_reported", {32'd0, hazard_stall}, 33'd1);
    step();
    check("stall_holds_lw", dut_pack(), exp_pack(find(32'h8C220004)));

    // Flush with stall and hazard: flush wins.
    flush = 1'b1;
    #1;
    check("flush_kills_hazard", {32'd0, hazard_stall}, 33'd0);
    step();
    check("flush_bubble", dut_pack(), 33'd0);
    flush = 1'b0;
    stall = 1'b0;

    // Stall alone holds add for three cycles while ID changes.
    issue(32'h00221820);
    stall = 1'b1;
    id_instr = 32'h00C72822;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_hold_%0d", k), dut_pack(), exp_pack(find(32'h00221820)));
    end
    stall = 1'b0;
    step();
    check("stall_release_issue", dut_pack(), exp_pack(find(32'h00C72822)));

    // Asynchronous reset mid-stall between edges.
    stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", dut_pack(), 33'd0);
    check("async_reset_hazard", {32'd0, hazard_stall}, 33'd0);
    stall = 1'b0;
    id_instr = 32'h00221820;
    #1;
    rst_n = 1'b1;
    step();
    check("post_reset_issue", dut_pack(), exp_pack(find(32'h00221820)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
